// File: rtl/reg_intf_pkg.sv
// Shared register-interface types: request/response structs, data widths and the
// responder wait-state FSM encoding.
package reg_intf_pkg;

    localparam int unsigned RegDataWidth = 32;
    localparam int unsigned RegStrbWidth = 4;

    typedef struct packed {
        logic                    valid;
        logic [31:0]             addr;
        logic                    write;
        logic [RegDataWidth-1:0] wdata;
        logic [RegStrbWidth-1:0] wstrb;
    } reg_req_t;

    typedef struct packed {
        logic                    ready;
        logic [RegDataWidth-1:0] rdata;
        logic                    error;
    } reg_rsp_t;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StAck
    } reg_state_e;

endpackage

// File: rtl/reg_intf_decode.sv
// Combinational address decode for a word-addressed register bank: register index
// plus an error flag for misaligned, out-of-range or read-only-write accesses.
module reg_intf_decode #(
    parameter int unsigned        NumRegs      = 8,
    parameter logic [31:0]        BaseAddr     = '0,
    parameter logic [NumRegs-1:0] ReadOnlyMask = '0,
    localparam int unsigned       IdxWidth     = (NumRegs > 1) ? $clog2(NumRegs) : 1
) (
    input  logic [31:0]         addr,
    input  logic                write,
    output logic [IdxWidth-1:0] idx,
    output logic                error
);

    logic [31:0] off;
    logic        in_range;
    logic        read_only;

    assign off      = addr - BaseAddr;
    assign in_range = {2'b00, off[31:2]} < NumRegs;
    assign idx      = off[IdxWidth+1:2];

    // Full-width match so out-of-range words never alias onto a mask bit.
    always_comb begin
        read_only = 1'b0;
        for (int unsigned i = 0; i < NumRegs; i++) begin
            if (off[31:2] == 30'(i)) begin
                read_only = ReadOnlyMask[i];
            end
        end
    end

    assign error = (off[1:0] != 2'b00) | ~in_range | (write & read_only);

endmodule

// File: rtl/reg_intf_regfile.sv
// Register-interface responder terminating bus transactions into NumRegs 32-bit
// registers, with optional wait states, byte strobes and hardware-side updates.
module reg_intf_regfile #(
    parameter int unsigned        NumRegs      = 8,
    parameter logic [31:0]        BaseAddr     = '0,
    parameter int unsigned        WaitCycles   = 0,
    parameter logic [NumRegs-1:0] ReadOnlyMask = '0,
    parameter logic [NumRegs*reg_intf_pkg::RegDataWidth-1:0] ResetValues = '0,
    parameter type                reg_req_t    = reg_intf_pkg::reg_req_t,
    parameter type                reg_rsp_t    = reg_intf_pkg::reg_rsp_t
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
    input  reg_req_t                                      req_i,
    output reg_rsp_t                                      rsp_o,
    output logic [NumRegs*reg_intf_pkg::RegDataWidth-1:0] regs_o,
    output logic [NumRegs-1:0]                            wr_pulse_o,
    input  logic [NumRegs-1:0]                            hw_we_i,
    input  logic [NumRegs*reg_intf_pkg::RegDataWidth-1:0] hw_wdata_i
);
    import reg_intf_pkg::*;

    localparam int unsigned IdxWidth = (NumRegs > 1) ? $clog2(NumRegs) : 1;

    logic [IdxWidth-1:0]     idx;
    logic                    dec_error;
    logic                    ready;
    logic                    done;
    logic                    bus_we;
    logic [RegDataWidth-1:0] rdata;
    logic [RegDataWidth-1:0] regs_q [NumRegs];
    logic [RegDataWidth-1:0] regs_d [NumRegs];
    logic [NumRegs-1:0]      pulse_q;
    logic [NumRegs-1:0]      pulse_d;

    reg_intf_decode #(
        .NumRegs      (NumRegs),
        .BaseAddr     (BaseAddr),
        .ReadOnlyMask (ReadOnlyMask)
    ) u_decode (
        .addr  (req_i.addr),
        .write (req_i.write),
        .idx   (idx),
        .error (dec_error)
    );

    if (WaitCycles == 0) begin : g_no_wait
        assign ready = req_i.valid & rst_ni;
    end else begin : g_wait
        localparam logic [3:0] LastCnt = 4'(WaitCycles - 1);

        reg_state_e state_q, state_d;
        logic [3:0] cnt_q, cnt_d;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_q <= StIdle;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            case (state_q)
                StIdle: begin
                    if (req_i.valid) begin
                        cnt_d   = 4'd1;
                        state_d = (WaitCycles == 1) ? StAck : StWait;
                    end
                end
                StWait: begin
                    // A request withdrawn mid-wait is abandoned without side effect.
                    if (!req_i.valid) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else if (cnt_q == LastCnt) begin
                        state_d = StAck;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                StAck: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end

        assign ready = (state_q == StAck);
    end

    assign done   = ready & req_i.valid;
    assign bus_we = done & req_i.write & ~dec_error;

    always_comb begin
        rdata = '0;
        for (int unsigned i = 0; i < NumRegs; i++) begin
            if (idx == IdxWidth'(i)) begin
                rdata = regs_q[i];
            end
        end
    end

    always_comb begin
        rsp_o       = '0;
        rsp_o.ready = ready;
        rsp_o.rdata = (done & ~req_i.write & ~dec_error) ? rdata : '0;
        rsp_o.error = done & dec_error;
    end

    // Hardware loads the full word first; strobed bus bytes then override it.
    always_comb begin
        pulse_d = '0;
        for (int unsigned i = 0; i < NumRegs; i++) begin
            regs_d[i] = regs_q[i];
            if (hw_we_i[i]) begin
                regs_d[i] = hw_wdata_i[RegDataWidth*i +: RegDataWidth];
            end
            pulse_d[i] = bus_we && (idx == IdxWidth'(i));
            if (pulse_d[i]) begin
                for (int unsigned b = 0; b < RegStrbWidth; b++) begin
                    if (req_i.wstrb[b]) begin
                        regs_d[i][8*b +: 8] = req_i.wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NumRegs; i++) begin
                regs_q[i] <= ResetValues[RegDataWidth*i +: RegDataWidth];
            end
            pulse_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NumRegs; i++) begin
                regs_q[i] <= regs_d[i];
            end
            pulse_q <= pulse_d;
        end
    end

    for (genvar i = 0; i < NumRegs; i++) begin : g_regs_out
        assign regs_o[RegDataWidth*i +: RegDataWidth] = regs_q[i];
    end

    assign wr_pulse_o = pulse_q;

endmodule

// File: tb/tb_reg_intf_regfile.sv
// Directed bench for reg_intf_regfile: three instances (0, 3 and 4 wait states)
// checked against a scoreboard of expected responses and a register model.
module tb_reg_intf_regfile;
    import reg_intf_pkg::*;

    localparam logic [255:0] RV  = {128'h0, 32'h3333_3333, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'h0};
    localparam logic [7:0]   ROM = 8'b0000_0010;

    typedef struct {
        logic [31:0] rdata;
        logic        error;
        int          lat;
    } exp_t;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    reg_req_t     req   [3];
    reg_rsp_t     rsp   [3];
    logic [255:0] regs  [3];
    logic [7:0]   pulse [3];
    logic [7:0]   hw_we [3];
    logic [255:0] hw_wd [3];
    logic [255:0] mdl   [3];
    exp_t         sb    [$];
    int           n_cmp = 0;
    int           n_err = 0;

    always #5 clk = ~clk;

    reg_intf_regfile #(
        .NumRegs(8), .BaseAddr(32'h0), .WaitCycles(0), .ReadOnlyMask(ROM), .ResetValues(RV)
    ) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req[0]), .rsp_o(rsp[0]), .regs_o(regs[0]),
        .wr_pulse_o(pulse[0]), .hw_we_i(hw_we[0]), .hw_wdata_i(hw_wd[0])
    );

    reg_intf_regfile #(
        .NumRegs(8), .BaseAddr(32'h0), .WaitCycles(3), .ReadOnlyMask(ROM), .ResetValues(RV)
    ) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req[1]), .rsp_o(rsp[1]), .regs_o(regs[1]),
        .wr_pulse_o(pulse[1]), .hw_we_i(hw_we[1]), .hw_wdata_i(hw_wd[1])
    );

    reg_intf_regfile #(
        .NumRegs(8), .BaseAddr(32'h0), .WaitCycles(4), .ReadOnlyMask(ROM), .ResetValues(RV)
    ) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req[2]), .rsp_o(rsp[2]), .regs_o(regs[2]),
        .wr_pulse_o(pulse[2]), .hw_we_i(hw_we[2]), .hw_wdata_i(hw_wd[2])
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one request from just after a rising edge; returns one cycle after ready.
    task automatic xact(input int d, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        input logic [31:0] exp_rdata, input logic exp_err, input int lat);
        exp_t e;
        bit   seen = 1'b0;
        sb.push_back('{rdata: exp_rdata, error: exp_err, lat: lat});
        req[d] = '{valid: 1'b1, addr: addr, write: wr, wdata: wdata, wstrb: strb};
        for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
            @(negedge clk);
            if (rsp[d].ready) begin
                e    = sb.pop_front();
                seen = 1'b1;
                chk($sformatf("d%0d@%0h latency", d, addr), 256'(cyc), 256'(e.lat));
                chk($sformatf("d%0d@%0h rdata", d, addr), 256'(rsp[d].rdata), 256'(e.rdata));
                chk($sformatf("d%0d@%0h error", d, addr), 256'(rsp[d].error), 256'(e.error));
                if (wr && !exp_err) begin
                    for (int b = 0; b < 4; b++) begin
                        if (strb[b]) mdl[d][32*addr[4:2] + 8*b +: 8] = wdata[8*b +: 8];
                    end
                end
            end
            @(posedge clk);
            #1;
        end
        req[d] = '0;
        if (!seen) begin
            e = sb.pop_front();
            chk($sformatf("d%0d@%0h ready timeout", d, addr), 256'(seen), 256'(1));
        end
    endtask

    task automatic post_chk(input int d, input logic [7:0] exp_pulse);
        @(negedge clk);
        chk($sformatf("d%0d wr_pulse", d), 256'(pulse[d]), 256'(exp_pulse));
        chk($sformatf("d%0d ready idle", d), 256'(rsp[d].ready), 256'(0));
        chk($sformatf("d%0d regs", d), regs[d], mdl[d]);
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            req[d]   = '0;
            hw_we[d] = '0;
            hw_wd[d] = '0;
            mdl[d]   = RV;
        end
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("d%0d reset regs", d), regs[d], RV);
            chk($sformatf("d%0d reset rsp", d), 256'(rsp[d]), 256'(0));
            chk($sformatf("d%0d reset pulse", d), 256'(pulse[d]), 256'(0));
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset contents visible, zero wait states, back to back
        xact(0, 1'b0, 32'h4, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 0);
        xact(0, 1'b0, 32'hC, 32'h0, 4'h0, 32'h3333_3333, 1'b0, 0);
        post_chk(0, 8'h00);

        // Three wait states, partial strobe write
        xact(1, 1'b1, 32'h8, 32'h1234_5678, 4'b0101, 32'h0, 1'b0, 3);
        chk("d1 reg2 strobed", 256'(regs[1][95:64]), 256'(32'hFF34_FF78));
        post_chk(1, 8'b0000_0100);
        xact(1, 1'b0, 32'h8, 32'h0, 4'h0, 32'hFF34_FF78, 1'b0, 3);

        // Misaligned and out-of-range
        xact(0, 1'b0, 32'h22, 32'h0, 4'h0, 32'h0, 1'b1, 0);
        xact(0, 1'b0, 32'h40, 32'h0, 4'h0, 32'h0, 1'b1, 0);
        post_chk(0, 8'h00);

        // Read-only register: bus write rejected, hardware write accepted
        xact(0, 1'b1, 32'h4, 32'hA5A5_A5A5, 4'hF, 32'h0, 1'b1, 0);
        post_chk(0, 8'h00);
        hw_we[0]          = 8'b0000_0010;
        hw_wd[0][63:32]   = 32'h0000_00FF;
        mdl[0][63:32]     = 32'h0000_00FF;
        @(posedge clk);
        #1;
        hw_we[0] = '0;
        post_chk(0, 8'h00);
        chk("d0 reg1 hw load", 256'(regs[0][63:32]), 256'(32'h0000_00FF));

        // Same-cycle bus and hardware write to register 0
        hw_we[0]        = 8'b0000_0001;
        hw_wd[0][31:0]  = 32'h1111_1111;
        mdl[0][31:0]    = 32'h1111_1111;
        xact(0, 1'b1, 32'h0, 32'h0000_BBBB, 4'b0011, 32'h0, 1'b0, 0);
        hw_we[0] = '0;
        post_chk(0, 8'b0000_0001);
        chk("d0 reg0 merge", 256'(regs[0][31:0]), 256'(32'h1111_BBBB));

        // Empty strobe: no data change, pulse still fires
        xact(0, 1'b1, 32'hC, 32'hFFFF_FFFF, 4'b0000, 32'h0, 1'b0, 0);
        post_chk(0, 8'b0000_1000);

        // Four wait states: valid withdrawn during WAIT
        req[2] = '{valid: 1'b1, addr: 32'h14, write: 1'b1, wdata: 32'hCAFE_F00D, wstrb: 4'hF};
        repeat (2) begin
            @(negedge clk);
            chk("d2 early ready", 256'(rsp[2].ready), 256'(0));
            @(posedge clk);
            #1;
        end
        req[2] = '0;
        repeat (4) begin
            @(negedge clk);
            chk("d2 abandoned ready", 256'(rsp[2].ready), 256'(0));
            chk("d2 abandoned pulse", 256'(pulse[2]), 256'(0));
            @(posedge clk);
            #1;
        end
        chk("d2 abandoned regs", regs[2], mdl[2]);
        xact(2, 1'b1, 32'h14, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0, 4);
        post_chk(2, 8'b0010_0000);

        // Reset in the middle of a transaction
        req[0] = '{valid: 1'b1, addr: 32'h4, write: 1'b0, wdata: 32'h0, wstrb: 4'h0};
        req[2] = '{valid: 1'b1, addr: 32'h18, write: 1'b1, wdata: 32'h5555_5555, wstrb: 4'hF};
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("d0 rsp in reset", 256'(rsp[0]), 256'(0));
        chk("d2 rsp in reset", 256'(rsp[2]), 256'(0));
        chk("d2 regs in reset", regs[2], RV);
        req[0] = '0;
        req[2] = '0;
        for (int d = 0; d < 3; d++) mdl[d] = RV;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        post_chk(2, 8'h00);
        xact(2, 1'b0, 32'h8, 32'h0, 4'h0, 32'hFFFF_FFFF, 1'b0, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
